// File: rtl/perif_responder.sv
// Memory-mapped peripheral slave: eight 16-bit output registers, a free-running
// cycle counter with compare/match flag, and registered read data for the bus.
module perif_responder #(
    parameter int BASE_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        perif_select,
    input  logic        mem_write_en,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    output logic        data_oe,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7,
    output logic        match_irq
);
    localparam int SLOT_W = BASE_W - 3;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    logic [15:0]       r_q [8];
    logic [15:0]       r_d [8];
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              flag_q, flag_d;
    logic [63:0]       data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;

    logic [SLOT_W-1:0] slot;
    logic              aligned;
    logic              hit_r, hit_count, hit_cmp, hit_stat;
    logic              wr_en, rd_en;
    logic [31:0]       wmask;
    logic [63:0]       rmask;
    logic [63:0]       rdata;
    logic              unused_bits;

    // Offsets are 8-byte slots; anything with low bits set decodes to nothing.
    assign slot      = address[BASE_W-1:3];
    assign aligned   = (address[2:0] == 3'b000);
    assign hit_r     = aligned && (slot < SLOT_W'(8));
    assign hit_count = aligned && (slot == SLOT_W'(8));
    assign hit_cmp   = aligned && (slot == SLOT_W'(9));
    assign hit_stat  = aligned && (slot == SLOT_W'(10));

    // A combined write+read strobe is treated as a write only.
    assign wr_en = perif_select && mem_write_en;
    assign rd_en = perif_select && mem_read && !mem_write_en;

    assign unused_bits = ^{address[31:BASE_W], data_in[63:32]};

    always_comb begin
        wmask = 32'hFFFF_FFFF;
        rmask = '1;
        case (size_e'(size))
            SZ_BYTE: begin
                wmask = 32'h0000_00FF;
                rmask = 64'h0000_0000_0000_00FF;
            end
            SZ_HALF: begin
                wmask = 32'h0000_FFFF;
                rmask = 64'h0000_0000_0000_FFFF;
            end
            SZ_WORD: begin
                wmask = 32'hFFFF_FFFF;
                rmask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                wmask = 32'hFFFF_FFFF;
                rmask = '1;
            end
        endcase
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        r_d        = r_q;
        cmp_d      = cmp_q;
        count_d    = count_q + 32'd1;
        flag_d     = flag_q;
        data_out_d = data_out_q;
        data_oe_d  = rd_en;
        rdata      = '0;

        if (wr_en) begin
            if (hit_r) begin
                r_d[slot[2:0]] = (r_q[slot[2:0]] & ~wmask[15:0]) | (data_in[15:0] & wmask[15:0]);
            end
            if (hit_cmp) begin
                cmp_d = (cmp_q & ~wmask) | (data_in[31:0] & wmask);
            end
            if (hit_count) begin
                count_d = '0;
            end
            if (hit_stat && data_in[0]) begin
                flag_d = 1'b0;
            end
        end

        // Set after the clear so a coincident match keeps the flag high.
        if ((count_d == cmp_q) && (cmp_q != '0)) begin
            flag_d = 1'b1;
        end

        if (hit_r) begin
            rdata = {48'd0, r_q[slot[2:0]]};
        end else if (hit_count) begin
            rdata = {32'd0, count_q};
        end else if (hit_cmp) begin
            rdata = {32'd0, cmp_q};
        end else if (hit_stat) begin
            rdata = {63'd0, flag_q};
        end

        if (rd_en) begin
            data_out_d = rdata & rmask;
        end
    end

    // NOTE: the register file is small and its reset value is architecturally visible, so it is reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
            count_q    <= '0;
            cmp_q      <= '0;
            flag_q     <= 1'b0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else begin
            r_q        <= r_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            flag_q     <= flag_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign r0        = r_q[0];
    assign r1        = r_q[1];
    assign r2        = r_q[2];
    assign r3        = r_q[3];
    assign r4        = r_q[4];
    assign r5        = r_q[5];
    assign r6        = r_q[6];
    assign r7        = r_q[7];
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign match_irq = flag_q;

endmodule
